// File: rtl/tamagotchi_input_sched.sv
// Button front-end for the pet-state FSM: synchroniser, debouncer,
// reset/test long-press timers and a round-robin care-action arbiter.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   btn_*                 raw active-high buttons (asynchronous)
//   act_valid/act_sel     care action offer (00 salud .. 11 diversion)
//   act_ready             FSM accepts the offered action
//   reset_req/test_req    one-cycle pulse after HOLD_SEC seconds held
//   count_reset/test      whole seconds held, saturating at HOLD_SEC
module tamagotchi_input_sched #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int TICK_DIV     = 50000000,
  parameter int HOLD_SEC     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_reset,
  input  logic       btn_test,
  output logic       act_valid,
  output logic [1:0] act_sel,
  input  logic       act_ready,
  output logic       reset_req,
  output logic       test_req,
  output logic [2:0] count_reset,
  output logic [2:0] count_test
);

  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int TKW = $clog2(TICK_DIV + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_DIV - 1);
  localparam logic [2:0]     HOLD    = 3'(HOLD_SEC);
  localparam logic [2:0]     HOLD_M1 = 3'(HOLD_SEC - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Button bit order: 0 salud, 1 energia, 2 hambre, 3 diversion,
  // 4 reset, 5 test.
  logic [5:0] raw;

  assign raw = {btn_test, btn_reset, btn_diversion,
                btn_hambre, btn_energia, btn_salud};

  // ---------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------
  logic [5:0]     s1_q, s1_d;
  logic [5:0]     s2_q, s2_d;
  logic [5:0]     db_q, db_d;
  logic [DBW-1:0] dbc_q [6];
  logic [DBW-1:0] dbc_d [6];

  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    db_d = db_q;
    for (int i = 0; i < 6; i++) begin
      dbc_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < 6; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      for (int i = 0; i < 6; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
    end
  end

  // ---------------------------------------------------------------
  // Long-press timers (index 0 reset, 1 test)
  // ---------------------------------------------------------------
  logic [TKW-1:0] tick_q [2];
  logic [TKW-1:0] tick_d [2];
  logic [2:0]     cnt_q [2];
  logic [2:0]     cnt_d [2];
  logic [1:0]     req_q, req_d;

  always_comb begin
    req_d = '0;
    for (int j = 0; j < 2; j++) begin
      tick_d[j] = '0;
      cnt_d[j]  = '0;
      if (db_q[4+j]) begin
        cnt_d[j] = cnt_q[j];
        if (tick_q[j] == TK_LAST) begin
          if (cnt_q[j] != HOLD) begin
            cnt_d[j] = cnt_q[j] + 3'd1;
          end
          // Only the HOLD-1 -> HOLD step fires, so one pulse per press.
          req_d[j] = (cnt_q[j] == HOLD_M1);
        end else begin
          tick_d[j] = tick_q[j] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      for (int j = 0; j < 2; j++) begin
        tick_q[j] <= '0;
        cnt_q[j]  <= '0;
      end
    end else begin
      req_q <= req_d;
      for (int j = 0; j < 2; j++) begin
        tick_q[j] <= tick_d[j];
        cnt_q[j]  <= cnt_d[j];
      end
    end
  end

  assign reset_req   = req_q[0];
  assign test_req    = req_q[1];
  assign count_reset = cnt_q[0];
  assign count_test  = cnt_q[1];

  // ---------------------------------------------------------------
  // Care-button pending bits and round-robin arbiter
  // ---------------------------------------------------------------
  logic [3:0] db_dly_q, db_dly_d;
  logic [3:0] rise;
  logic [3:0] pend_q, pend_d;
  logic [3:0] clr;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  state_e     state_q, state_d;
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;

  assign db_dly_d = db_q[3:0];
  assign rise     = db_q[3:0] & ~db_dly_q;

  // First pending button strictly after the last grant.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && pend_q[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OFFER;
          valid_d = 1'b1;
          sel_d   = pick;
        end
      end
      OFFER: begin
        if (valid_q && act_ready) begin
          clr     = 4'b0001 << sel_q;
          ptr_d   = sel_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A press landing in the acceptance cycle survives the clear.
    pend_d = (pend_q & ~clr) | rise;
    // Long reset aborts any offer; act_ready is ignored this cycle.
    if (req_q[0]) begin
      pend_d  = '0;
      valid_d = 1'b0;
      ptr_d   = '0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_dly_q <= '0;
      pend_q   <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      state_q  <= IDLE;
    end else begin
      db_dly_q <= db_dly_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      state_q  <= state_d;
    end
  end

  assign act_valid = valid_q;
  assign act_sel   = sel_q;

endmodule

// File: tb/tb_tamagotchi_input_sched.sv
// Directed bench for tamagotchi_input_sched with small timing
// parameters (DEBOUNCE_CYC=4, TICK_DIV=10, HOLD_SEC=5).
module tb_tamagotchi_input_sched;

  logic       clk;
  logic       rst_n;
  logic       btn_salud;
  logic       btn_energia;
  logic       btn_hambre;
  logic       btn_diversion;
  logic       btn_reset;
  logic       btn_test;
  logic       act_valid;
  logic [1:0] act_sel;
  logic       act_ready;
  logic       reset_req;
  logic       test_req;
  logic [2:0] count_reset;
  logic [2:0] count_test;

  int vecs;
  int errs;

  tamagotchi_input_sched #(
    .DEBOUNCE_CYC(4),
    .TICK_DIV(10),
    .HOLD_SEC(5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_salud(btn_salud),
    .btn_energia(btn_energia),
    .btn_hambre(btn_hambre),
    .btn_diversion(btn_diversion),
    .btn_reset(btn_reset),
    .btn_test(btn_test),
    .act_valid(act_valid),
    .act_sel(act_sel),
    .act_ready(act_ready),
    .reset_req(reset_req),
    .test_req(test_req),
    .count_reset(count_reset),
    .count_test(count_test)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_all();
    btn_salud     = 1'b0;
    btn_energia   = 1'b0;
    btn_hambre    = 1'b0;
    btn_diversion = 1'b0;
    btn_reset     = 1'b0;
    btn_test      = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst_n     = 1'b0;
    act_ready = 1'b1;
    release_all();
    #3;
    got = {act_valid, act_sel, reset_req, test_req,
           count_reset, count_test};
    vecs++;
    if (got !== 10'd0) begin
      errs++;
      $display("FAIL reset_outputs got=%b want=0", got);
    end
    step(1);
    rst_n = 1'b1;
    step(3);
    vecs++;
    if (act_valid !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle act_valid got=%b want=0", act_valid);
    end
  endtask

  task automatic test_single_press();
    int acc;
    acc = 0;
    act_ready = 1'b1;
    btn_hambre = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (k == 7) begin
        vecs++;
        if (act_valid !== 1'b0) begin
          errs++;
          $display("FAIL single_early k=7 valid=%b want=0", act_valid);
        end
      end
      if (k == 8) begin
        vecs++;
        if (act_valid !== 1'b1 || act_sel !== 2'b10) begin
          errs++;
          $display("FAIL single_offer valid=%b sel=%b want 1/10",
                   act_valid, act_sel);
        end
      end
      if (act_valid && act_ready) acc++;
    end
    vecs++;
    if (acc != 1) begin
      errs++;
      $display("FAIL single_count got=%0d want=1", acc);
    end
    btn_hambre = 1'b0;
    step(10);
    acc = 0;
    btn_salud = 1'b1;
    step(3);
    btn_salud = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (act_valid) acc++;
    end
    vecs++;
    if (acc != 0) begin
      errs++;
      $display("FAIL glitch_action got=%0d want=0", acc);
    end
  endtask

  task automatic test_round_robin();
    logic       exp_v;
    logic [1:0] exp_s;
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    act_ready = 1'b1;
    btn_salud     = 1'b1;
    btn_energia   = 1'b1;
    btn_hambre    = 1'b1;
    btn_diversion = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      exp_v = (k == 8 || k == 10 || k == 12 || k == 14);
      exp_s = 2'((k - 6) / 2);
      if (k >= 7) begin
        vecs++;
        if (act_valid !== exp_v ||
            (exp_v && act_sel !== exp_s)) begin
          errs++;
          $display("FAIL rr k=%0d valid=%b sel=%b want %b/%b",
                   k, act_valid, act_sel, exp_v, exp_s);
        end
      end
    end
    release_all();
    step(10);
  endtask

  task automatic test_backpressure();
    int bad;
    int acc;
    bad = 0;
    acc = 0;
    act_ready = 1'b0;
    btn_energia = 1'b1;
    step(7);
    for (int k = 8; k <= 27; k++) begin
      step(1);
      if (act_valid !== 1'b1 || act_sel !== 2'b01) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL bp_hold bad_cycles=%0d want=0", bad);
    end
    act_ready = 1'b1;
    step(1);
    vecs++;
    if (act_valid !== 1'b0) begin
      errs++;
      $display("FAIL bp_accept valid=%b want=0", act_valid);
    end
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (act_valid) acc++;
    end
    vecs++;
    if (acc != 0) begin
      errs++;
      $display("FAIL bp_extra got=%0d want=0", acc);
    end
    btn_energia = 1'b0;
    step(10);
  endtask

  task automatic test_long_hold(input bit early_release);
    int         ec;
    logic       er;
    act_ready = 1'b1;
    btn_reset = 1'b1;
    btn_test  = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step(1);
      ec = (k < 6) ? 0 : (k - 6) / 10;
      if (ec > 5) ec = 5;
      if (early_release && k >= 52) ec = 0;
      er = !early_release && (k == 56);
      vecs++;
      if (count_reset !== 3'(ec) || reset_req !== er ||
          count_test !== 3'(ec) || test_req !== er) begin
        errs++;
        $display("FAIL hold rel=%0d k=%0d cr=%0d rr=%b ct=%0d tr=%b want %0d/%b",
                 early_release, k, count_reset, reset_req,
                 count_test, test_req, ec, er);
      end
      if (early_release && k == 45) begin
        btn_reset = 1'b0;
        btn_test  = 1'b0;
      end
    end
    btn_reset = 1'b0;
    btn_test  = 1'b0;
    step(8);
    vecs++;
    if (count_reset !== 3'd0 || count_test !== 3'd0) begin
      errs++;
      $display("FAIL hold_clear cr=%0d ct=%0d want 0",
               count_reset, count_test);
    end
  endtask

  task automatic test_abort();
    int acc;
    acc = 0;
    act_ready = 1'b1;
    btn_diversion = 1'b1;
    step(8);
    vecs++;
    if (act_valid !== 1'b1 || act_sel !== 2'b11) begin
      errs++;
      $display("FAIL abort_pre valid=%b sel=%b want 1/11",
               act_valid, act_sel);
    end
    step(1);
    btn_diversion = 1'b0;
    step(10);
    act_ready   = 1'b0;
    btn_reset   = 1'b1;
    btn_energia = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      step(1);
      if (k == 8) begin
        vecs++;
        if (act_valid !== 1'b1 || act_sel !== 2'b01) begin
          errs++;
          $display("FAIL abort_offer valid=%b sel=%b want 1/01",
                   act_valid, act_sel);
        end
      end
    end
    vecs++;
    if (reset_req !== 1'b1 || act_valid !== 1'b1) begin
      errs++;
      $display("FAIL abort_req rr=%b valid=%b want 1/1",
               reset_req, act_valid);
    end
    act_ready = 1'b1;
    step(1);
    vecs++;
    if (act_valid !== 1'b0 || reset_req !== 1'b0) begin
      errs++;
      $display("FAIL abort_drop valid=%b rr=%b want 0/0",
               act_valid, reset_req);
    end
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (act_valid) acc++;
    end
    vecs++;
    if (acc != 0) begin
      errs++;
      $display("FAIL abort_reoffer got=%0d want=0", acc);
    end
    release_all();
    step(10);
    btn_salud  = 1'b1;
    btn_hambre = 1'b1;
    step(8);
    vecs++;
    if (act_valid !== 1'b1 || act_sel !== 2'b10) begin
      errs++;
      $display("FAIL abort_ptr valid=%b sel=%b want 1/10",
               act_valid, act_sel);
    end
    step(2);
    vecs++;
    if (act_valid !== 1'b1 || act_sel !== 2'b00) begin
      errs++;
      $display("FAIL abort_next valid=%b sel=%b want 1/00",
               act_valid, act_sel);
    end
    release_all();
    step(10);
  endtask

  task automatic test_async_reset();
    logic [9:0] got;
    int         bad;
    bad = 0;
    act_ready   = 1'b0;
    btn_energia = 1'b1;
    btn_reset   = 1'b1;
    step(20);
    vecs++;
    if (act_valid !== 1'b1 || count_reset !== 3'd1) begin
      errs++;
      $display("FAIL async_pre valid=%b cr=%0d want 1/1",
               act_valid, count_reset);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {act_valid, act_sel, reset_req, test_req,
           count_reset, count_test};
    vecs++;
    if (got !== 10'd0) begin
      errs++;
      $display("FAIL async_outputs got=%b want=0", got);
    end
    release_all();
    step(3);
    rst_n = 1'b1;
    act_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (act_valid || reset_req || test_req ||
          count_reset != 3'd0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL async_after bad_cycles=%0d want=0", bad);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_press();
    test_round_robin();
    test_backpressure();
    test_long_hold(1'b0);
    test_long_hold(1'b1);
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
